k_sync_fifo_n: RTL and testbench
================================

Name: k_sync_fifo_n

Overview:
Single-clock, parametrised successor to the 2-deep FIFO. It generalises depth to 2^ADDR_SIZE and keeps the wput/wrdy and rget/rrdy handshakes. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is used as the general in-domain buffer between pipeline stages sharing one clock.

Parameters:
DATA_SIZE, 8, width of each data word
ADDR_SIZE, 2, log2 of depth; depth = 2^ADDR_SIZE (ADDR_SIZE >= 1)
AFULL_TH, 3, afull asserted when count >= AFULL_TH (1..depth)
AEMPTY_TH, 1, aempty asserted when count <= AEMPTY_TH (0..depth-1)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties FIFO, clears error flags
wdata  input  DATA_SIZE  write data
wput  input  1  write request
wrdy  output  1  FIFO not full; write accepted when wput & wrdy
rdata  output  DATA_SIZE  head-of-queue word (first-word-fall-through); valid only while rrdy=1
rget  input  1  read request; pops head when rget & rrdy
rrdy  output  1  FIFO not empty
count  output  ADDR_SIZE+1  current occupancy, 0..depth
afull  output  1  count >= AFULL_TH
aempty  output  1  count <= AEMPTY_TH
ovf  output  1  sticky: wput seen while wrdy=0
udf  output  1  sticky: rget seen while rrdy=0

Behaviour:
- Clock domain: one clock (clk); reset is asynchronous, active-low (rst_n).
- Storage: 2^ADDR_SIZE x DATA_SIZE array, written on clk, not reset. Read is combinational: rdata = mem[rptr[ADDR_SIZE-1:0]].
- Pointers: wptr and rptr are ADDR_SIZE+1 bits and wrap naturally mod 2^(ADDR_SIZE+1).
  - empty = (wptr == rptr).
  - full = MSBs differ and lower bits equal.
- count = wptr - rptr, truncated to ADDR_SIZE+1 bits. It is registered, or derived combinationally from the registered pointers only, never from current-cycle inputs.
- Outputs: wrdy = !full; rrdy = !empty.
  - afull, aempty, wrdy and rrdy are pure functions of the registered state, so they change only after a clk edge or on reset.
- Reset (rst_n=0, immediate): wptr=rptr=0, ovf=udf=0.
  - Outputs during reset: wrdy=1, rrdy=0, count=0, afull=0 (AFULL_TH>=1), aempty=1. rdata is don't-care.
- Write: on a clk edge with wput & wrdy & !clr, mem[wptr] <= wdata and wptr increments.
- Read: on a clk edge with rget & rrdy & !clr, rptr increments.
- Latency: a word written at edge N gives rrdy=1 with rdata = that word after edge N (first usable pop at edge N+1). A pop at edge N frees the slot, so wrdy=1 after edge N.
- Simultaneous put and get, neither blocked: both pointers advance and count is unchanged.
- When full: wrdy=0, so wput is rejected even if rget pops in the same cycle. No write-through-when-full.
- When empty: rget is rejected even if wput writes in the same cycle. No bypass; the data appears the next cycle.
- Rejected requests: pointers and memory unchanged.
  - wput & !wrdy sets ovf; rget & !rrdy sets udf.
  - Both flags hold until clr or reset.
- clr: has priority over wput/rget in the same cycle. At the edge, wptr <= 0, rptr <= 0, ovf <= 0, udf <= 0. Memory is untouched, and requests in that cycle are neither performed nor flagged.
- Reset mid-operation: immediately returns all state to reset values. Any in-flight data is lost.

Test Plan (DATA_SIZE=8, ADDR_SIZE=2, AFULL_TH=3, AEMPTY_TH=1 unless stated):
1. Reset, then 4 puts of 0x11,0x22,0x33,0x44 with rget=0 -> count 1,2,3,4; afull=1 at count 3; wrdy=0 at count 4; rrdy=1 after first edge with rdata=0x11; aempty=0 at count 2.
2. From full, 5th wput=0x55 -> rejected, ovf=1, count stays 4. Then 4 gets -> rdata sequence 0x11,0x22,0x33,0x44 (no 0x55), rrdy=0 at end.
3. Empty FIFO, rget=1 for one cycle -> udf=1, count 0. The same cycle with wput=1, wdata=0xA5 -> write taken, rrdy=1 next cycle, rdata=0xA5.
4. Count=2, then continuous wput & rget for 20 cycles with incrementing data -> count stays 2, output order matches input order across multiple pointer wraps.
5. Count=4 with ovf=1, assert clr together with wput and rget -> next cycle count=0, rrdy=0, wrdy=1, ovf=udf=0, aempty=1. A subsequent put/get round-trips correctly.
6. Count=3, assert rst_n=0 between clk edges -> outputs go to reset values without a clk edge. After release, 2 puts and 2 gets behave as in scenario 1.

Source files
------------

// File: rtl/k_sync_fifo_n.sv
// k_sync_fifo_n: single-clock FIFO with 2^ADDR_SIZE entries and first-word-fall-through reads.
// Ports:
//   clk, rst_n     - clock; asynchronous active-low reset
//   clr            - synchronous flush (empties FIFO, clears error flags)
//   wdata, wput    - write data / write request; accepted when wput & wrdy
//   wrdy           - FIFO not full
//   rdata, rget    - head-of-queue word / read request; pops when rget & rrdy
//   rrdy           - FIFO not empty
//   count          - occupancy 0..depth
//   afull, aempty  - count >= AFULL_TH / count <= AEMPTY_TH
//   ovf, udf       - sticky overflow / underflow flags
module k_sync_fifo_n #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 2,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wput,
  output logic                 wrdy,
  output logic [DATA_SIZE-1:0] rdata,
  input  logic                 rget,
  output logic                 rrdy,
  output logic [ADDR_SIZE:0]   count,
  output logic                 afull,
  output logic                 aempty,
  output logic                 ovf,
  output logic                 udf
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned PW    = ADDR_SIZE + 1;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic                 r_ovf;
  logic                 r_udf;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [PW-1:0]        w_count;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                   (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign w_count = r_wptr - r_rptr;

  // Flush wins over both requests; blocked requests never move a pointer.
  assign w_wr_en = wput && !w_full  && !clr;
  assign w_rd_en = rget && !w_empty && !clr;

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[PW-2:0]] <= wdata;
    end
  end

  // Pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PW'(1);
      if (w_rd_en) r_rptr <= r_rptr + PW'(1);
    end
  end

  // Sticky error flags; requests in a flush cycle are not flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wput && w_full)  r_ovf <= 1'b1;
      if (rget && w_empty) r_udf <= 1'b1;
    end
  end

  // Status outputs depend only on registered state.
  assign wrdy   = !w_full;
  assign rrdy   = !w_empty;
  assign count  = w_count;
  assign afull  = (w_count >= PW'(AFULL_TH));
  assign aempty = (w_count <= PW'(AEMPTY_TH));
  assign ovf    = r_ovf;
  assign udf    = r_udf;
  assign rdata  = r_mem[r_rptr[PW-2:0]];

endmodule

// File: tb/tb_k_sync_fifo_n.sv
// Scoreboard bench for k_sync_fifo_n (DATA_SIZE=8, ADDR_SIZE=2, AFULL_TH=3, AEMPTY_TH=1).
module tb_k_sync_fifo_n;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] wdata;
  logic       wput;
  logic       wrdy;
  logic [7:0] rdata;
  logic       rget;
  logic       rrdy;
  logic [2:0] count;
  logic       afull;
  logic       aempty;
  logic       ovf;
  logic       udf;

  k_sync_fifo_n #(
    .DATA_SIZE(8), .ADDR_SIZE(2), .AFULL_TH(3), .AEMPTY_TH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wdata(wdata), .wput(wput), .wrdy(wrdy),
    .rdata(rdata), .rget(rget), .rrdy(rrdy), .count(count), .afull(afull),
    .aempty(aempty), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [8:0] st;   // {count, wrdy, rrdy, afull, aempty, ovf, udf}
    logic       chk_rd;
    logic [7:0] rd;
  } st_exp_t;

  st_exp_t    exp_st[$];
  logic [7:0] exp_data[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         st_id = 0;
  logic       done  = 1'b0;

  // Queue the required status for the current cycle; checked at the next negedge.
  task automatic chk_st(input logic [2:0] c, input logic w, input logic r, input logic af,
                        input logic ae, input logic ov, input logic ud,
                        input logic chk, input logic [7:0] rd);
    st_exp_t e;
    e.id = st_id;
    e.st = {c, w, r, af, ae, ov, ud};
    e.chk_rd = chk;
    e.rd = rd;
    st_id++;
    exp_st.push_back(e);
  endtask

  // Apply one cycle of requests, return 2 time units after the edge.
  task automatic drive(input logic wp, input logic [7:0] wd, input logic rg, input logic cl);
    wput = wp; wdata = wd; rget = rg; clr = cl;
    @(posedge clk); #2;
    wput = 1'b0; rget = 1'b0; clr = 1'b0;
  endtask

  task automatic put(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic [7:0] d);
    exp_data.push_back(d);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: checks every pop handshake and every queued status expectation.
  initial begin
    st_exp_t    s;
    logic [7:0] e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (rst_n && rget && rrdy && !clr) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_bad++;
          $display("FAIL pop_unexpected: got rdata=%h, required no pop", rdata);
        end else begin
          e = exp_data.pop_front();
          if (rdata !== e) begin
            n_bad++;
            $display("FAIL pop_data: got rdata=%h, required %h", rdata, e);
          end
        end
      end
      while (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        got = {count, wrdy, rrdy, afull, aempty, ovf, udf};
        n_cmp++;
        if (got !== s.st) begin
          n_bad++;
          $display("FAIL status#%0d: got {cnt,wrdy,rrdy,af,ae,ovf,udf}=%0d,%b%b%b%b%b%b required %0d,%b%b%b%b%b%b",
                   s.id, got[8:6], got[5], got[4], got[3], got[2], got[1], got[0],
                   s.st[8:6], s.st[5], s.st[4], s.st[3], s.st[2], s.st[1], s.st[0]);
        end
        if (s.chk_rd) begin
          n_cmp++;
          if (rdata !== s.rd) begin
            n_bad++;
            $display("FAIL head#%0d: got rdata=%h, required %h", s.id, rdata, s.rd);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_data.size() != 0) begin
          n_bad++;
          $display("FAIL pops_missing: got %0d expected pops outstanding, required 0", exp_data.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000, required summary");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    rst_n = 1'b0; clr = 1'b0; wput = 1'b0; rget = 1'b0; wdata = 8'h00;
    @(posedge clk); #2;
    chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    rst_n = 1'b1;

    // 1: fill to full
    put(8'h11); chk_st(3'd1, 1, 1, 0, 1, 0, 0, 1, 8'h11);
    put(8'h22); chk_st(3'd2, 1, 1, 0, 0, 0, 0, 1, 8'h11);
    put(8'h33); chk_st(3'd3, 1, 1, 1, 0, 0, 0, 1, 8'h11);
    put(8'h44); chk_st(3'd4, 0, 1, 1, 0, 0, 0, 1, 8'h11);

    // 2: overflow then drain
    put(8'h55); chk_st(3'd4, 0, 1, 1, 0, 1, 0, 1, 8'h11);
    pop(8'h11); chk_st(3'd3, 1, 1, 1, 0, 1, 0, 1, 8'h22);
    pop(8'h22); chk_st(3'd2, 1, 1, 0, 0, 1, 0, 1, 8'h33);
    pop(8'h33); chk_st(3'd1, 1, 1, 0, 1, 1, 0, 1, 8'h44);
    pop(8'h44); chk_st(3'd0, 1, 0, 0, 1, 1, 0, 0, 8'h00);

    // 3: underflow, then get+put on empty: only the put is taken
    drive(1'b0, 8'h00, 1'b1, 1'b0); chk_st(3'd0, 1, 0, 0, 1, 1, 1, 0, 8'h00);
    drive(1'b1, 8'hA5, 1'b1, 1'b0); chk_st(3'd1, 1, 1, 0, 1, 1, 1, 1, 8'hA5);
    pop(8'hA5); chk_st(3'd0, 1, 0, 0, 1, 1, 1, 0, 8'h00);

    // 4: steady-state streaming at count 2 across pointer wraps
    put(8'h01); chk_st(3'd1, 1, 1, 0, 1, 1, 1, 1, 8'h01);
    put(8'h02); chk_st(3'd2, 1, 1, 0, 0, 1, 1, 1, 8'h01);
    for (int i = 0; i < 20; i++) begin
      exp_data.push_back(8'(1 + i));
      drive(1'b1, 8'(3 + i), 1'b1, 1'b0);
      chk_st(3'd2, 1, 1, 0, 0, 1, 1, 1, 8'(2 + i));
    end
    pop(8'h15); chk_st(3'd1, 1, 1, 0, 1, 1, 1, 1, 8'h16);
    pop(8'h16); chk_st(3'd0, 1, 0, 0, 1, 1, 1, 0, 8'h00);

    // 5: flush has priority over simultaneous put/get
    put(8'hB0); put(8'hB1); put(8'hB2); put(8'hB3);
    chk_st(3'd4, 0, 1, 1, 0, 1, 1, 1, 8'hB0);
    drive(1'b1, 8'hEE, 1'b1, 1'b1); chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    put(8'hC3); chk_st(3'd1, 1, 1, 0, 1, 0, 0, 1, 8'hC3);
    pop(8'hC3); chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);

    // 6: asynchronous reset mid-operation
    put(8'h61); put(8'h62); put(8'h63);
    chk_st(3'd3, 1, 1, 1, 0, 0, 0, 1, 8'h61);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    put(8'h71); chk_st(3'd1, 1, 1, 0, 1, 0, 0, 1, 8'h71);
    put(8'h72); chk_st(3'd2, 1, 1, 0, 0, 0, 0, 1, 8'h71);
    pop(8'h71); chk_st(3'd1, 1, 1, 0, 1, 0, 0, 1, 8'h72);
    pop(8'h72); chk_st(3'd0, 1, 0, 0, 1, 0, 0, 0, 8'h00);

    done = 1'b1;
  end

endmodule
